nanosoc_systable_walker: RTL

- AHB-Lite initiator that discovers the nanosoc System ROM Table at SYSTABLE_BASE.
- On a start pulse it reads entries until the terminator or MAX_ENTRIES, decodes component base addresses and present flags, then reads and checks PIDR0/1/2 and CIDR1.
- Sits on a spare manager port of the system interconnect (debug/boot-discovery use); results are held in registers for firmware or the bench.

---
 rtl/nanosoc_systable_pkg.sv | 37 +++
 rtl/nanosoc_ahb_single_reader.sv | 56 +++++
 rtl/nanosoc_systable_walker.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/nanosoc_systable_pkg.sv
// Shared types and constants for the nanosoc system ROM table walker.
package nanosoc_systable_pkg;

  typedef enum logic [2:0] {
    W_IDLE,
    W_ENTRY,
    W_PIDR0,
    W_PIDR1,
    W_PIDR2,
    W_CIDR1,
    W_DONE
  } walk_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rd_state_t;

  localparam logic [11:0] OFF_PIDR0 = 12'hFE0;
  localparam logic [11:0] OFF_PIDR1 = 12'hFE4;
  localparam logic [11:0] OFF_PIDR2 = 12'hFE8;
  localparam logic [11:0] OFF_CIDR1 = 12'hFF4;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [3:0] ROM_CLASS = 4'h1;

  function automatic logic [31:0] id_addr(
    input logic [31:0] base,
    input logic [11:0] off
  );
    return base + {20'h0, off};
  endfunction

endpackage

// File: rtl/nanosoc_ahb_single_reader.sv
// Single-outstanding AHB-Lite read engine: one address phase, one data
// phase, no pipelining. Error responses are folded into rd_err.
module nanosoc_ahb_single_reader
  import nanosoc_systable_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'hF000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  output logic        rd_done,
  output logic [31:0] rd_data,
  output logic        rd_err,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic        hresp
);

  rd_state_t state;
  rd_state_t state_n;
  logic      err_seen;

  assign rd_done = (state == R_DATA) && hready;
  assign rd_err  = rd_done && (hresp || err_seen);
  assign rd_data = hrdata;
  assign htrans  = (state == R_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;

  always_comb begin
    state_n = state;
    case (state)
      R_IDLE: if (rd_req) state_n = R_ADDR;
      R_ADDR: if (hready) state_n = R_DATA;
      R_DATA: if (hready) state_n = rd_req ? R_ADDR : R_IDLE;
      default: state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= R_IDLE;
      haddr    <= RESET_ADDR;
      err_seen <= 1'b0;
    end else begin
      state <= state_n;
      if (rd_req && (state == R_IDLE || rd_done))
        haddr <= rd_addr;
      // first cycle of a two-cycle error arrives with hready low
      if (state == R_DATA)
        err_seen <= hready ? 1'b0 : (err_seen | hresp);
    end
  end

endmodule

// File: rtl/nanosoc_systable_walker.sv
// Walks the system ROM table on a start pulse, decodes entries and
// checks the peripheral/component ID registers.
module nanosoc_systable_walker
  import nanosoc_systable_pkg::*;
#(
  parameter int          SYS_ADDR_W    = 32,
  parameter int          SYS_DATA_W    = 32,
  parameter logic [31:0] SYSTABLE_BASE = 32'hF000_0000,
  parameter int          MAX_ENTRIES   = 4,
  parameter int          ENTRY_IDX_W   = 2
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [ENTRY_IDX_W:0]    num_entries,
  input  logic [ENTRY_IDX_W-1:0]  entry_sel,
  output logic [31:0]             entry_base,
  output logic                    entry_present,
  output logic [6:0]              jep_id,
  output logic [11:0]             part_num,
  output logic [3:0]              revision,
  output logic [SYS_ADDR_W-1:0]   HADDR,
  output logic [1:0]              HTRANS,
  output logic                    HWRITE,
  output logic [2:0]              HSIZE,
  output logic [2:0]              HBURST,
  output logic [3:0]              HPROT,
  output logic                    HMASTLOCK,
  output logic [SYS_DATA_W-1:0]   HWDATA,
  input  logic [SYS_DATA_W-1:0]   HRDATA,
  input  logic                    HREADY,
  input  logic                    HRESP
);

  localparam logic [ENTRY_IDX_W:0] ONE  = 1;
  localparam logic [ENTRY_IDX_W:0] LAST =
    (ENTRY_IDX_W+1)'(MAX_ENTRIES - 1);

  walk_state_t state;
  walk_state_t state_n;

  logic                 rd_req;
  logic [31:0]          rd_addr;
  logic                 rd_done;
  logic [31:0]          rd_data;
  logic                 rd_err;

  logic                 error_q;
  logic [ENTRY_IDX_W:0] num_q;
  logic [ENTRY_IDX_W:0] num_nxt;
  logic [31:0]          base_q [MAX_ENTRIES];
  logic                 present_q [MAX_ENTRIES];
  logic [6:0]           jep_q;
  logic [11:0]          part_q;
  logic [3:0]           rev_q;

  nanosoc_ahb_single_reader #(
    .RESET_ADDR (SYSTABLE_BASE)
  ) u_reader (
    .clk     (HCLK),
    .rst     (HRESET),
    .rd_req  (rd_req),
    .rd_addr (rd_addr),
    .rd_done (rd_done),
    .rd_data (rd_data),
    .rd_err  (rd_err),
    .haddr   (HADDR),
    .htrans  (HTRANS),
    .hrdata  (HRDATA),
    .hready  (HREADY),
    .hresp   (HRESP)
  );

  assign HWRITE    = 1'b0;
  assign HSIZE     = 3'b010;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;
  assign HWDATA    = '0;

  assign busy        = (state != W_IDLE) && (state != W_DONE);
  assign done        = (state == W_DONE);
  assign error       = error_q;
  assign num_entries = num_q;
  assign num_nxt     = num_q + ONE;
  assign jep_id      = jep_q;
  assign part_num    = part_q;
  assign revision    = rev_q;

  assign entry_base    = base_q[entry_sel];
  assign entry_present = present_q[entry_sel] &&
                         ({1'b0, entry_sel} < num_q);

  always_comb begin
    state_n = state;
    rd_req  = 1'b0;
    rd_addr = SYSTABLE_BASE;
    case (state)
      W_IDLE: begin
        if (start) begin
          rd_req  = 1'b1;
          state_n = W_ENTRY;
        end
      end
      W_ENTRY: begin
        if (rd_done) begin
          if (rd_err) begin
            state_n = W_DONE;
          end else if (rd_data == '0 ||
                       (rd_data[1] && num_q == LAST)) begin
            rd_req  = 1'b1;
            rd_addr = id_addr(SYSTABLE_BASE, OFF_PIDR0);
            state_n = W_PIDR0;
          end else if (!rd_data[1]) begin
            state_n = W_DONE;
          end else begin
            rd_req  = 1'b1;
            rd_addr = SYSTABLE_BASE +
              {{(SYS_ADDR_W-ENTRY_IDX_W-3){1'b0}}, num_nxt, 2'b00};
          end
        end
      end
      W_PIDR0: begin
        if (rd_done) begin
          rd_req  = !rd_err;
          rd_addr = id_addr(SYSTABLE_BASE, OFF_PIDR1);
          state_n = rd_err ? W_DONE : W_PIDR1;
        end
      end
      W_PIDR1: begin
        if (rd_done) begin
          rd_req  = !rd_err;
          rd_addr = id_addr(SYSTABLE_BASE, OFF_PIDR2);
          state_n = rd_err ? W_DONE : W_PIDR2;
        end
      end
      W_PIDR2: begin
        if (rd_done) begin
          rd_req  = !rd_err;
          rd_addr = id_addr(SYSTABLE_BASE, OFF_CIDR1);
          state_n = rd_err ? W_DONE : W_CIDR1;
        end
      end
      W_CIDR1: if (rd_done) state_n = W_DONE;
      W_DONE:  state_n = W_IDLE;
      default: state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state   <= W_IDLE;
      error_q <= 1'b0;
      num_q   <= '0;
      jep_q   <= '0;
      part_q  <= '0;
      rev_q   <= '0;
      for (int i = 0; i < MAX_ENTRIES; i++) begin
        base_q[i]    <= '0;
        present_q[i] <= 1'b0;
      end
    end else begin
      state <= state_n;
      case (state)
        W_IDLE: begin
          if (start) begin
            error_q <= 1'b0;
            num_q   <= '0;
            jep_q   <= '0;
            part_q  <= '0;
            rev_q   <= '0;
            for (int i = 0; i < MAX_ENTRIES; i++) begin
              base_q[i]    <= '0;
              present_q[i] <= 1'b0;
            end
          end
        end
        W_ENTRY: begin
          if (rd_done) begin
            if (rd_err || (rd_data != '0 && !rd_data[1])) begin
              error_q <= 1'b1;
            end else if (rd_data != '0) begin
              base_q[num_q[ENTRY_IDX_W-1:0]] <=
                SYSTABLE_BASE + {rd_data[31:12], 12'h000};
              present_q[num_q[ENTRY_IDX_W-1:0]] <= rd_data[0];
              num_q <= num_nxt;
            end
          end
        end
        W_PIDR0: begin
          if (rd_done) begin
            if (rd_err) error_q <= 1'b1;
            else part_q[7:0] <= rd_data[7:0];
          end
        end
        W_PIDR1: begin
          if (rd_done) begin
            if (rd_err) begin
              error_q <= 1'b1;
            end else begin
              part_q[11:8] <= rd_data[3:0];
              jep_q[3:0]   <= rd_data[7:4];
            end
          end
        end
        W_PIDR2: begin
          if (rd_done) begin
            if (rd_err) begin
              error_q <= 1'b1;
            end else begin
              jep_q[6:4] <= rd_data[2:0];
              rev_q      <= rd_data[7:4];
            end
          end
        end
        W_CIDR1: begin
          if (rd_done && (rd_err || rd_data[7:4] != ROM_CLASS))
            error_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
